// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-wide memory controller.
// Grant encodings, FSM state enum and the RAM address width.
package mem_pkg;

    localparam int ADDR_WIDTH = 17;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } mem_state_t;

    // The grant id of the opposite port in a two-port arbiter.
    function automatic logic other_id(logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Cache request ports and RAM bus of the memory controller.
// slave = the controller side, master = the caches/RAM side.
interface mem_ctrl_if;
    import mem_pkg::*;

    logic                  icache_get_en;
    logic [ADDR_WIDTH-1:0] icache_addr;
    logic                  icache_out_en;
    logic [7:0]            icache_content;

    logic                  dcache_get_en;
    logic                  dcache_wr;
    logic [ADDR_WIDTH-1:0] dcache_addr;
    logic [7:0]            dcache_wdata;
    logic                  dcache_out_en;
    logic [7:0]            dcache_content;

    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    modport slave (
        input  icache_get_en,
        input  icache_addr,
        output icache_out_en,
        output icache_content,
        input  dcache_get_en,
        input  dcache_wr,
        input  dcache_addr,
        input  dcache_wdata,
        output dcache_out_en,
        output dcache_content,
        input  mem_din,
        output mem_dout,
        output mem_a,
        output mem_wr
    );

    modport master (
        output icache_get_en,
        output icache_addr,
        input  icache_out_en,
        input  icache_content,
        output dcache_get_en,
        output dcache_wr,
        output dcache_addr,
        output dcache_wdata,
        input  dcache_out_en,
        input  dcache_content,
        output mem_din,
        input  mem_dout,
        input  mem_a,
        input  mem_wr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin pick between the ICache and DCache.
// Purely combinational; the caller owns the last_grant register.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic ICACHE_ID = GRANT_I
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant
);

    localparam logic DCACHE_ID = other_id(ICACHE_ID);

    // On a tie the port that did not own the previous burst wins.
    always_comb begin
        grant = ICACHE_ID;
        if (req_i && req_d) begin
            grant = other_id(last_grant);
        end else if (req_d) begin
            grant = DCACHE_ID;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM responder shared by the ICache and DCache.
// Issues at most one RAM access per cycle; response is 1 cycle later.
module mem_ctrl #(
    parameter int   ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter logic ICACHE_ID  = mem_pkg::GRANT_I
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    localparam logic DCACHE_ID = mem_pkg::other_id(ICACHE_ID);

    mem_pkg::mem_state_t   state_q;
    mem_pkg::mem_state_t   state_d;
    logic                  last_q;
    logic                  last_d;
    logic                  grant;
    logic                  issue_i;
    logic                  issue_d;
    logic                  issue;
    logic                  resp_i_q;
    logic                  resp_d_q;
    logic [ADDR_WIDTH-1:0] a_sel;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [7:0]            dout_q;

    mem_arbiter #(
        .ICACHE_ID (ICACHE_ID)
    ) u_arb (
        .req_i      (bus.icache_get_en),
        .req_d      (bus.dcache_get_en),
        .last_grant (last_q),
        .grant      (grant)
    );

    // Next state and issue decision; reset blocks any issue so the
    // RAM bus reads as zero while rst is held.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        issue_i = 1'b0;
        issue_d = 1'b0;
        if (!rst) begin
            unique case (state_q)
                mem_pkg::IDLE: begin
                    if (bus.icache_get_en || bus.dcache_get_en) begin
                        if (grant == ICACHE_ID) begin
                            issue_i = 1'b1;
                            state_d = mem_pkg::SERVE_I;
                        end else begin
                            issue_d = 1'b1;
                            state_d = mem_pkg::SERVE_D;
                        end
                    end
                end
                mem_pkg::SERVE_I: begin
                    if (bus.icache_get_en) begin
                        issue_i = 1'b1;
                    end else begin
                        last_d  = ICACHE_ID;
                        state_d = mem_pkg::IDLE;
                    end
                end
                mem_pkg::SERVE_D: begin
                    if (bus.dcache_get_en) begin
                        issue_d = 1'b1;
                    end else begin
                        last_d  = DCACHE_ID;
                        state_d = mem_pkg::IDLE;
                    end
                end
                default: begin
                    state_d = mem_pkg::IDLE;
                end
            endcase
        end
    end

    assign issue = issue_i | issue_d;

    // Address mux; with no issue the last address is held.
    always_comb begin
        a_sel = a_q;
        if (issue_i) begin
            a_sel = bus.icache_addr;
        end else if (issue_d) begin
            a_sel = bus.dcache_addr;
        end
    end

    assign bus.mem_a    = a_sel;
    assign bus.mem_wr   = issue_d & bus.dcache_wr;
    assign bus.mem_dout = issue_d ? bus.dcache_wdata : dout_q;

    assign bus.icache_out_en  = resp_i_q;
    assign bus.dcache_out_en  = resp_d_q;
    assign bus.icache_content = resp_i_q ? bus.mem_din : 8'h00;
    assign bus.dcache_content = resp_d_q ? bus.mem_din : 8'h00;

    // State and round-robin history; DCache starts as last owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= mem_pkg::IDLE;
            last_q  <= DCACHE_ID;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Response strobes: one per issue, visible the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_i_q <= 1'b0;
            resp_d_q <= 1'b0;
        end else begin
            resp_i_q <= issue_i;
            resp_d_q <= issue_d;
        end
    end

    // Holding registers for the RAM address and write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            dout_q <= 8'h00;
        end else begin
            if (issue) begin
                a_q <= a_sel;
            end
            if (issue_d) begin
                dout_q <= bus.dcache_wdata;
            end
        end
    end

endmodule
